// File: rtl/sig_gen_pkg.sv
// ---------------------------------------------------------------------------
// sig_gen_pkg
// Shared definitions for the signal-generator key controller:
//   - waveform-select encodings (WAVE_SINE/SQUARE/TRI/SAW)
//   - frequency step table (1, 10, 100, 1000) and step-index width
//   - double-press FSM state encoding
// No ports (package).
// ---------------------------------------------------------------------------
package sig_gen_pkg;

  localparam int STEP_IDX_W = 2;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_e;

  localparam logic [31:0] STEP_TABLE_0 = 32'd1;
  localparam logic [31:0] STEP_TABLE_1 = 32'd10;
  localparam logic [31:0] STEP_TABLE_2 = 32'd100;
  localparam logic [31:0] STEP_TABLE_3 = 32'd1000;

  typedef enum logic {
    DP_IDLE  = 1'b0,
    DP_WAIT2 = 1'b1
  } dp_state_e;

  // Frequency increment selected by the active step index.
  function automatic logic [31:0] step_value(input logic [STEP_IDX_W-1:0] idx);
    logic [31:0] val;
    case (idx)
      2'd0:    val = STEP_TABLE_0;
      2'd1:    val = STEP_TABLE_1;
      2'd2:    val = STEP_TABLE_2;
      default: val = STEP_TABLE_3;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/sig_gen_dbl_press.sv
// ---------------------------------------------------------------------------
// sig_gen_dbl_press
// Single/double press classifier for one debounced key pulse.
// A first press opens a window of DBL_WIN cycles. A second press at any edge
// t+1 .. t+DBL_WIN (inclusive) is a double press; otherwise the window closes
// at edge t+DBL_WIN and a single press is reported.
// single_evt/double_evt are combinational and valid in the cycle before the
// deciding edge, so the consumer registers the result at that same edge.
// Ports:
//   sys_clk     in  clock
//   sys_rst_n   in  asynchronous active-low reset
//   key_flag    in  1-cycle key pulse
//   single_evt  out window expired without a second press (this edge)
//   double_evt  out second press inside the window (this edge)
//   pend        out registered: a first press awaits its decision
// ---------------------------------------------------------------------------
module sig_gen_dbl_press
  import sig_gen_pkg::*;
#(
  parameter logic [23:0] DBL_WIN = 24'd50
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_flag,
  output logic single_evt,
  output logic double_evt,
  output logic pend
);

  dp_state_e   state_q, state_d;
  logic [23:0] cnt_q, cnt_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= DP_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // At edge t+k after the first press, cnt_q holds k-1.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    single_evt = 1'b0;
    double_evt = 1'b0;
    case (state_q)
      DP_IDLE: begin
        if (key_flag) begin
          state_d = DP_WAIT2;
          cnt_d   = '0;
        end
      end
      DP_WAIT2: begin
        cnt_d = cnt_q + 24'd1;
        if (key_flag) begin
          double_evt = 1'b1;
          state_d    = DP_IDLE;
          cnt_d      = '0;
        end else if (cnt_q == DBL_WIN - 24'd1) begin
          single_evt = 1'b1;
          state_d    = DP_IDLE;
          cnt_d      = '0;
        end
      end
      default: begin
        state_d = DP_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign pend = (state_q == DP_WAIT2);

endmodule

// File: rtl/sig_gen_key_ctrl.sv
// ---------------------------------------------------------------------------
// sig_gen_key_ctrl
// Turns debounced key pulses into the signal-generator configuration
// (waveform select, frequency tuning word, step index). Key actions update
// the registered outputs at the edge that samples the flag.
// Optional build macro: SIG_KEY_FREQ_WRAP_EN
//   defined   -> up past FREQ_MAX loads FREQ_MIN, down below FREQ_MIN loads FREQ_MAX
//   undefined -> frequency saturates at FREQ_MIN / FREQ_MAX
// Ports:
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   key_wave_flag        waveform key (single: next waveform, double: defaults)
//   key_up_flag          frequency up by current step
//   key_down_flag        frequency down by current step
//   key_step_flag        cycle step index 0..3
//   wave_sel             0 sine, 1 square, 2 triangle, 3 sawtooth
//   freq_word            frequency tuning word
//   step_idx             active step index
//   wave_pend            waveform press awaiting its window decision
//   cfg_valid            1-cycle pulse after any configuration change
// ---------------------------------------------------------------------------
module sig_gen_key_ctrl
  import sig_gen_pkg::*;
#(
  parameter int                FREQ_W       = 32,
  parameter logic [FREQ_W-1:0] FREQ_DEFAULT = 32'd500,
  parameter logic [FREQ_W-1:0] FREQ_MIN     = 32'd100,
  parameter logic [FREQ_W-1:0] FREQ_MAX     = 32'd1000,
  parameter logic [23:0]       DBL_WIN      = 24'd50
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  key_wave_flag,
  input  logic                  key_up_flag,
  input  logic                  key_down_flag,
  input  logic                  key_step_flag,
  output logic [1:0]            wave_sel,
  output logic [FREQ_W-1:0]     freq_word,
  output logic [STEP_IDX_W-1:0] step_idx,
  output logic                  wave_pend,
  output logic                  cfg_valid
);

  logic [1:0]            wave_q, wave_d;
  logic [FREQ_W-1:0]     freq_q, freq_d;
  logic [STEP_IDX_W-1:0] step_q, step_d;
  logic                  cfg_valid_q, cfg_valid_d;

  logic single_evt, double_evt, pend;

  sig_gen_dbl_press #(
    .DBL_WIN (DBL_WIN)
  ) u_wave_press (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_flag   (key_wave_flag),
    .single_evt (single_evt),
    .double_evt (double_evt),
    .pend       (pend)
  );

  // Frequency arithmetic, one bit wider to expose overflow/underflow.
  logic [FREQ_W-1:0] step_val;
  logic [FREQ_W:0]   sum, diff;
  logic [FREQ_W-1:0] freq_up, freq_down;
  logic              up_only, down_only;

  assign step_val  = FREQ_W'(step_value(step_q));
  assign sum       = {1'b0, freq_q} + {1'b0, step_val};
  assign diff      = {1'b0, freq_q} - {1'b0, step_val};
  assign up_only   = key_up_flag & ~key_down_flag;
  assign down_only = key_down_flag & ~key_up_flag;

  always_comb begin
    freq_up = sum[FREQ_W-1:0];
    if (sum > {1'b0, FREQ_MAX}) begin
`ifdef SIG_KEY_FREQ_WRAP_EN
      freq_up = FREQ_MIN;
`else
      freq_up = FREQ_MAX;
`endif
    end
  end

  // diff[FREQ_W] set means freq_q < step_val (underflow).
  always_comb begin
    freq_down = diff[FREQ_W-1:0];
    if (diff[FREQ_W] || (diff[FREQ_W-1:0] < FREQ_MIN)) begin
`ifdef SIG_KEY_FREQ_WRAP_EN
      freq_down = FREQ_MAX;
`else
      freq_down = FREQ_MIN;
`endif
    end
  end

  always_comb begin
    wave_d = wave_q;
    freq_d = freq_q;
    step_d = step_q;
    if (up_only)       freq_d = freq_up;
    if (down_only)     freq_d = freq_down;
    // Step advances alongside up/down; arithmetic above used the old step.
    if (key_step_flag) step_d = step_q + 1'b1;
    if (single_evt)    wave_d = wave_q + 2'd1;
    // Default restore wins over any same-edge key action.
    if (double_evt) begin
      wave_d = WAVE_SINE;
      freq_d = FREQ_DEFAULT;
      step_d = '0;
    end
    cfg_valid_d = (wave_d != wave_q) || (freq_d != freq_q) || (step_d != step_q);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wave_q      <= WAVE_SINE;
      freq_q      <= FREQ_DEFAULT;
      step_q      <= '0;
      cfg_valid_q <= 1'b0;
    end else begin
      wave_q      <= wave_d;
      freq_q      <= freq_d;
      step_q      <= step_d;
      cfg_valid_q <= cfg_valid_d;
    end
  end

  assign wave_sel  = wave_q;
  assign freq_word = freq_q;
  assign step_idx  = step_q;
  assign wave_pend = pend;
  assign cfg_valid = cfg_valid_q;

endmodule

// File: tb/tb_sig_gen_key_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sig_gen_key_ctrl
// Directed stimulus with a scoreboard: each action that must change the
// configuration pushes the expected {wave_sel, freq_word, step_idx}; a
// monitor pops and compares on every cfg_valid pulse. Build with
// +define+SIG_KEY_FREQ_WRAP_EN to check the wrapping variant.
// ---------------------------------------------------------------------------
module tb_sig_gen_key_ctrl;

  typedef struct packed {
    logic [1:0]  w;
    logic [31:0] f;
    logic [1:0]  s;
  } cfg_t;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        key_wave_flag, key_up_flag, key_down_flag, key_step_flag;
  logic [1:0]  wave_sel;
  logic [31:0] freq_word;
  logic [1:0]  step_idx;
  logic        wave_pend;
  logic        cfg_valid;

  int   checks   = 0;
  int   failures = 0;
  cfg_t exp_q[$];
  cfg_t exp_cfg;

  sig_gen_key_ctrl #(
    .FREQ_W       (32),
    .FREQ_DEFAULT (32'd500),
    .FREQ_MIN     (32'd100),
    .FREQ_MAX     (32'd1000),
    .DBL_WIN      (24'd50)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .key_wave_flag (key_wave_flag),
    .key_up_flag   (key_up_flag),
    .key_down_flag (key_down_flag),
    .key_step_flag (key_step_flag),
    .wave_sel      (wave_sel),
    .freq_word     (freq_word),
    .step_idx      (step_idx),
    .wave_pend     (wave_pend),
    .cfg_valid     (cfg_valid)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Monitor: one line per configuration transaction.
  always @(negedge sys_clk) begin
    if (sys_rst_n && cfg_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_cfg_valid got wave=%0d freq=%0d step=%0d required no pulse",
                 wave_sel, freq_word, step_idx);
      end else begin
        exp_cfg = exp_q.pop_front();
        if ({wave_sel, freq_word, step_idx} !== exp_cfg) begin
          failures++;
          $display("FAIL cfg_update got wave=%0d freq=%0d step=%0d required wave=%0d freq=%0d step=%0d",
                   wave_sel, freq_word, step_idx, exp_cfg.w, exp_cfg.f, exp_cfg.s);
        end else begin
          $display("cfg_valid wave=%0d freq=%0d step=%0d ok", wave_sel, freq_word, step_idx);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic expect_cfg(input logic [1:0] w, input logic [31:0] f, input logic [1:0] s);
    cfg_t c;
    c.w = w;
    c.f = f;
    c.s = s;
    exp_q.push_back(c);
  endtask

  // Flags set now, sampled at the next posedge (edge t); returns at t+1ns.
  task automatic press(input logic w, input logic u, input logic d, input logic s);
    key_wave_flag = w;
    key_up_flag   = u;
    key_down_flag = d;
    key_step_flag = s;
    @(posedge sys_clk);
    #1;
    key_wave_flag = 1'b0;
    key_up_flag   = 1'b0;
    key_down_flag = 1'b0;
    key_step_flag = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_wave_sel"},  {30'd0, wave_sel},  32'd0);
    check({tag, "_freq_word"}, freq_word,          32'd500);
    check({tag, "_step_idx"},  {30'd0, step_idx},  32'd0);
    check({tag, "_wave_pend"}, {31'd0, wave_pend}, 32'd0);
    check({tag, "_cfg_valid"}, {31'd0, cfg_valid}, 32'd0);
  endtask

  initial begin
    sys_rst_n     = 1'b0;
    key_wave_flag = 1'b0;
    key_up_flag   = 1'b0;
    key_down_flag = 1'b0;
    key_step_flag = 1'b0;

    // 1. reset values
    idle(3);
    check_reset_state("in_reset");
    sys_rst_n = 1'b1;
    idle(2);
    check_reset_state("after_reset");

    // 2. four isolated waveform presses walk 1,2,3,0
    for (int i = 0; i < 4; i++) begin
      expect_cfg(2'((i + 1) % 4), 32'd500, 2'd0);
      press(1'b1, 1'b0, 1'b0, 1'b0);
      check("single_pend_high", {31'd0, wave_pend}, 32'd1);
      idle(49);
      check("single_no_early_advance", {30'd0, wave_sel}, 32'(i % 4));
      idle(1);
      check("single_advance", {30'd0, wave_sel}, 32'((i + 1) % 4));
      check("single_pend_low", {31'd0, wave_pend}, 32'd0);
      idle(3);
    end

    // 3a. double press at t+20 restores defaults
    expect_cfg(2'd0, 32'd500, 2'd1);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    expect_cfg(2'd0, 32'd500, 2'd0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    idle(19);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    check("dbl20_step_restored", {30'd0, step_idx}, 32'd0);
    check("dbl20_pend_low", {31'd0, wave_pend}, 32'd0);
    idle(40);
    check("dbl20_no_advance", {30'd0, wave_sel}, 32'd0);

    // 3b. second press exactly at t+50 is still a double press
    expect_cfg(2'd0, 32'd500, 2'd1);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    expect_cfg(2'd0, 32'd500, 2'd0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    idle(49);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    check("dbl50_step_restored", {30'd0, step_idx}, 32'd0);
    check("dbl50_pend_low", {31'd0, wave_pend}, 32'd0);
    idle(20);
    check("dbl50_no_advance", {30'd0, wave_sel}, 32'd0);

    // 4. step to 1000, up saturates (or wraps)
    expect_cfg(2'd0, 32'd500, 2'd1);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    expect_cfg(2'd0, 32'd500, 2'd2);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    expect_cfg(2'd0, 32'd500, 2'd3);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    expect_cfg(2'd0, 32'd1000, 2'd3);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    check("up_to_max", freq_word, 32'd1000);
`ifdef SIG_KEY_FREQ_WRAP_EN
    expect_cfg(2'd0, 32'd100, 2'd3);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    check("up_wrap", freq_word, 32'd100);
`else
    press(1'b0, 1'b1, 1'b0, 1'b0);
    check("up_saturate", freq_word, 32'd1000);
`endif
    idle(2);

    // 5. restore defaults, then step=1 and combined key cases
    expect_cfg(2'd0, 32'd500, 2'd0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    idle(9);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    expect_cfg(2'd0, 32'd500, 2'd1);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    check("up_down_ignored", freq_word, 32'd500);
    expect_cfg(2'd0, 32'd490, 2'd1);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    check("down_step10", freq_word, 32'd490);
    expect_cfg(2'd0, 32'd500, 2'd2);
    press(1'b0, 1'b1, 1'b0, 1'b1);
    check("step_up_old_step_freq", freq_word, 32'd500);
    check("step_up_new_idx", {30'd0, step_idx}, 32'd2);
    expect_cfg(2'd0, 32'd500, 2'd3);
    press(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef SIG_KEY_FREQ_WRAP_EN
    expect_cfg(2'd0, 32'd1000, 2'd3);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    check("down_underflow_wrap", freq_word, 32'd1000);
`else
    expect_cfg(2'd0, 32'd100, 2'd3);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    check("down_underflow_sat", freq_word, 32'd100);
`endif
    idle(2);

    // 6. reset in the middle of a pending window
    press(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_pend_before", {31'd0, wave_pend}, 32'd1);
    idle(10);
    sys_rst_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    idle(5);
    sys_rst_n = 1'b1;
    idle(46);
    check_reset_state("post_reset_window");

    // drain scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge sys_clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sig_gen_key_ctrl.md
Name: sig_gen_key_ctrl

Overview:
Consumes the single-cycle debounced key_flag pulses from four key_filter instances and turns them into the signal-generator configuration: waveform select, frequency tuning word and frequency step size. The waveform key supports double-press detection: one press advances the waveform, a double press restores the default configuration. Outputs feed the DDS phase accumulator and waveform ROM select.

Parameters:
FREQ_W, 32, width of freq_word
FREQ_DEFAULT, 32'd500, freq_word after reset and after a double press
FREQ_MIN, 32'd100, lower bound of freq_word
FREQ_MAX, 32'd1000, upper bound of freq_word
DBL_WIN, 24'd50, double-press window in sys_clk cycles (≥2); 24'd1_000_000 on board

Ports:
sys_clk        in   1       system clock
sys_rst_n      in   1       asynchronous active-low reset
key_wave_flag  in   1       1-cycle pulse, waveform key pressed
key_up_flag    in   1       1-cycle pulse, frequency up
key_down_flag  in   1       1-cycle pulse, frequency down
key_step_flag  in   1       1-cycle pulse, cycle step size
wave_sel       out  2       0 sine, 1 square, 2 triangle, 3 sawtooth
freq_word      out  FREQ_W  frequency tuning word
step_idx       out  2       active step index into STEP_TABLE
wave_pend      out  1       high while a waveform press awaits the window decision
cfg_valid      out  1       1-cycle pulse when wave_sel/freq_word/step_idx changed

Behaviour:
- Reset (async, sys_rst_n low): wave_sel=0, freq_word=FREQ_DEFAULT, step_idx=0, wave_pend=0, cfg_valid=0, window counter=0, FSM=IDLE.
- All outputs registered. An action updates outputs at the same clock edge that samples the flag, so there is no extra latency.
- Step key: step_idx wraps 3→0. Step value = STEP_TABLE[step_idx] = 1, 10, 100, 1000.
- Up: sum computed in FREQ_W+1 bits. If the sum exceeds FREQ_MAX, freq_word saturates to FREQ_MAX.
- Down: if freq_word−step is below FREQ_MIN (including underflow), freq_word saturates to FREQ_MIN.
- Up and down flags in the same cycle: both ignored.
- Step flag together with up or down: up/down uses the old step_idx, and step_idx advances in the same edge.
- Waveform FSM:
  - IDLE: wave flag at edge t → WAIT2, counter cleared, wave_pend=1.
  - WAIT2: counter increments each cycle.
    - Wave flag at edge t+k, 1≤k≤DBL_WIN → restore defaults (wave_sel=0, freq_word=FREQ_DEFAULT, step_idx=0) at that edge, then go to IDLE.
    - No second flag by edge t+DBL_WIN → wave_sel increments (3→0) at edge t+DBL_WIN, then go to IDLE.
    - A second flag exactly at edge t+DBL_WIN counts as a double press.
  - A default restore overrides any same-edge up/down/step action.
  - Up/down/step are processed normally while in WAIT2.
- cfg_valid is high for one cycle after any edge where at least one of wave_sel/freq_word/step_idx changed value. A saturated press with no change produces no pulse.
- Reset during WAIT2: the pending press is discarded and no advance follows release.

Optional Feature:
SIG_KEY_FREQ_WRAP_EN
- Defined: up past FREQ_MAX loads FREQ_MIN; down below FREQ_MIN loads FREQ_MAX. cfg_valid pulses on every such press.
- Undefined: saturating behaviour as specified above.

Decomposition:
- Package sig_gen_pkg holds:
  - wave-select encodings WAVE_SINE/SQUARE/TRI/SAW
  - STEP_TABLE constants (1, 10, 100, 1000)
  - step-index width
- Sub-module sig_gen_dbl_press: IDLE/WAIT2 FSM plus window counter, parameterised by DBL_WIN. Outputs single_evt, double_evt, pend. Instantiated once for the waveform key. The top level holds the config registers and saturation arithmetic.

Test Plan (defaults above, DBL_WIN=50):
1. Reset release → wave_sel=0, freq_word=500, step_idx=0, cfg_valid=0, wave_pend=0.
2. Single wave pulse at edge t → wave_pend high from t; wave_sel 0→1 at t+50 with one cfg_valid. Four isolated presses walk 1,2,3,0.
3. Wave pulses at t and t+20 → defaults restored at t+20, wave_pend low after it, no advance at t+50. Pulses at t and t+50 → also treated as a double press.
4. Three step presses (step_idx=3), then up → freq_word 1000 with cfg_valid. Second up → stays 1000, no cfg_valid. With SIG_KEY_FREQ_WRAP_EN → 100.
5. step_idx=1, freq_word=500: up and down together → freq_word 500, no cfg_valid. Down alone → 490. Step and up together → freq_word 500 (old step 10), step_idx=2.
6. Wave pulse, then sys_rst_n low at t+10 and released at t+15 → outputs at reset values and no wave_sel change through t+60.
